// File: rtl/vga_timing_gen.sv
// Raster timing generator: active-low Hsync/Vsync, DE, pixel/line position and start pulses.
// Define VGATG_CLKEN_EN to add the CE pixel clock enable input; otherwise the block advances every edge.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        Hsync,
    output logic        Vsync,
    output logic        DE,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        line_start,
    output logic        frame_start,
    output logic [1:0]  h_state_dbg,
    output logic [1:0]  v_state_dbg
`ifdef VGATG_CLKEN_EN
    ,
    input  logic        CE
`endif
);

    // Phase encoding is visible on h_state_dbg / v_state_dbg: 0=ACT 1=FP 2=SYN 3=BP.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_t;

    phase_t      h_state, h_state_next;
    phase_t      v_state, v_state_next;
    logic [10:0] hcnt, hcnt_next;
    logic [10:0] h_pcnt, h_pcnt_next;
    logic [10:0] h_len;
    logic [9:0]  vcnt, vcnt_next;
    logic [9:0]  v_pcnt, v_pcnt_next;
    logic [9:0]  v_len;
    logic        h_last, h_wrap, v_last;
    logic        adv;

    logic        hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
    logic [10:0] hpos_d;
    logic [9:0]  vpos_d;

`ifdef VGATG_CLKEN_EN
    assign adv = CE;
`else
    assign adv = 1'b1;
`endif

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_ACT:  next_phase = PH_FP;
            PH_FP:   next_phase = PH_SYN;
            PH_SYN:  next_phase = PH_BP;
            default: next_phase = PH_ACT;
        endcase
    endfunction

    always_comb begin
        h_len = 11'(H_BP);
        case (h_state)
            PH_ACT:  h_len = 11'(H_ACTIVE);
            PH_FP:   h_len = 11'(H_FP);
            PH_SYN:  h_len = 11'(H_SYNC);
            default: h_len = 11'(H_BP);
        endcase
    end

    always_comb begin
        v_len = 10'(V_BP);
        case (v_state)
            PH_ACT:  v_len = 10'(V_ACTIVE);
            PH_FP:   v_len = 10'(V_FP);
            PH_SYN:  v_len = 10'(V_SYNC);
            default: v_len = 10'(V_BP);
        endcase
    end

    // Horizontal axis: the phase counter restarts on every phase change; leaving BP is the line wrap.
    always_comb begin
        h_state_next = h_state;
        h_pcnt_next  = h_pcnt + 11'd1;
        hcnt_next    = hcnt + 11'd1;
        h_wrap       = 1'b0;
        h_last       = (h_pcnt == h_len - 11'd1);
        if (h_last) begin
            h_pcnt_next  = '0;
            h_state_next = next_phase(h_state);
            if (h_state == PH_BP) begin
                h_wrap    = 1'b1;
                hcnt_next = '0;
            end
        end
    end

    // Vertical axis steps once per line, on the edge where the horizontal axis wraps.
    always_comb begin
        v_state_next = v_state;
        v_pcnt_next  = v_pcnt;
        vcnt_next    = vcnt;
        v_last       = (v_pcnt == v_len - 10'd1);
        if (h_wrap) begin
            if (v_last) begin
                v_pcnt_next  = '0;
                v_state_next = next_phase(v_state);
                vcnt_next    = (v_state == PH_BP) ? 10'd0 : vcnt + 10'd1;
            end else begin
                v_pcnt_next = v_pcnt + 10'd1;
                vcnt_next   = vcnt + 10'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_state <= PH_ACT;
            v_state <= PH_ACT;
            hcnt    <= '0;
            h_pcnt  <= '0;
            vcnt    <= '0;
            v_pcnt  <= '0;
        end else if (adv) begin
            h_state <= h_state_next;
            v_state <= v_state_next;
            hcnt    <= hcnt_next;
            h_pcnt  <= h_pcnt_next;
            vcnt    <= vcnt_next;
            v_pcnt  <= v_pcnt_next;
        end
    end

    // Output decode of the current counter state; registered below so outputs lag the counters by one edge.
    always_comb begin
        de_d          = (h_state == PH_ACT) && (v_state == PH_ACT);
        hsync_d       = (h_state != PH_SYN);
        vsync_d       = (v_state != PH_SYN);
        hpos_d        = de_d ? hcnt : 11'd0;
        vpos_d        = de_d ? vcnt : 10'd0;
        line_start_d  = (hcnt == 11'd0);
        frame_start_d = (hcnt == 11'd0) && (vcnt == 10'd0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Hsync       <= 1'b1;
            Vsync       <= 1'b1;
            DE          <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (adv) begin
            Hsync       <= hsync_d;
            Vsync       <= vsync_d;
            DE          <= de_d;
            hpos        <= hpos_d;
            vpos        <= vpos_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
        end
    end

    assign h_state_dbg = h_state;
    assign v_state_dbg = v_state;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 mode plus a tiny 4,1,1,1 / 2,1,1,1 mode for whole-frame checks.
// Build with VGATG_CLKEN_EN defined to also exercise the CE input.
module tb_vga_timing_gen;

    localparam int SH_A = 4, SH_F = 1, SH_S = 1, SH_B = 1;
    localparam int SV_A = 2, SV_F = 1, SV_S = 1, SV_B = 1;

    logic        clk;
    logic        rst_n;
    logic        hsync, vsync, de, ls, fs;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic [1:0]  hdbg, vdbg;
    logic        s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic [10:0] s_hpos;
    logic [9:0]  s_vpos;
    logic [1:0]  s_hdbg, s_vdbg;
`ifdef VGATG_CLKEN_EN
    logic        ce;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_gen dut (
        .CLK(clk), .RESET_N(rst_n), .Hsync(hsync), .Vsync(vsync), .DE(de),
        .hpos(hpos), .vpos(vpos), .line_start(ls), .frame_start(fs),
        .h_state_dbg(hdbg), .v_state_dbg(vdbg)
`ifdef VGATG_CLKEN_EN
        , .CE(ce)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
    ) dut_s (
        .CLK(clk), .RESET_N(rst_n), .Hsync(s_hsync), .Vsync(s_vsync), .DE(s_de),
        .hpos(s_hpos), .vpos(s_vpos), .line_start(s_ls), .frame_start(s_fs),
        .h_state_dbg(s_hdbg), .v_state_dbg(s_vdbg)
`ifdef VGATG_CLKEN_EN
        , .CE(ce)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {Hsync,Vsync,DE,hpos,vpos,line_start,frame_start} for output sample k after reset release.
    function automatic logic [25:0] model(input int k, input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf, input int vs,
                                          input int vb);
        int  ht, vt, h, v;
        logic e_de;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        h    = k % ht;
        v    = (k / ht) % vt;
        e_de = (h < ha) && (v < va);
        return {!(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs), e_de,
                e_de ? 11'(h) : 11'd0, e_de ? 10'(v) : 10'd0, h == 0, (h == 0) && (v == 0)};
    endfunction

    function automatic logic [25:0] model_def(input int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [25:0] model_small(input int k);
        return model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
    endfunction

    // Driver: hold reset a few cycles, release on a falling edge; next rising edge yields sample 0.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [25:0] rst_val;
        rst_val = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hsync, vsync, de, hpos, vpos, ls, fs} !== rst_val) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {hsync, vsync, de, hpos, vpos, ls, fs}, rst_val);
        end
        checks++;
        if ({s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs} !== rst_val) begin
            errors++;
            $display("FAIL reset_outputs_small got=%h exp=%h",
                     {s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs}, rst_val);
        end
        checks++;
        if ({hdbg, vdbg, s_hdbg, s_vdbg} !== 8'h00) begin
            errors++;
            $display("FAIL reset_fsm_act got=%h exp=00", {hdbg, vdbg, s_hdbg, s_vdbg});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({hsync, vsync, de, hpos, vpos, ls, fs} !== {1'b1, 1'b1, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_edge got=%h exp=%h", {hsync, vsync, de, hpos, vpos, ls, fs},
                     {1'b1, 1'b1, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1});
        end
        checks++;
        if ({s_de, s_ls, s_fs, s_hsync, s_vsync} !== 5'b11111) begin
            errors++;
            $display("FAIL first_edge_small got=%b exp=11111", {s_de, s_ls, s_fs, s_hsync, s_vsync});
        end
    endtask

    task automatic test_line();
        int de_cnt, hs_cnt, ls_cnt, hs_first;
        logic [25:0] got, exp;
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0; hs_first = -1;
        do_reset();
        for (int k = 0; k <= 800; k++) begin
            @(negedge clk);
            got = {hsync, vsync, de, hpos, vpos, ls, fs};
            exp = model_def(k);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL line_sample k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k < 800) begin
                if (de) de_cnt++;
                if (ls) ls_cnt++;
                if (!hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = k;
                end
            end
        end
        checks++;
        if (de_cnt != 640) begin
            errors++;
            $display("FAIL line_de_count got=%0d exp=640", de_cnt);
        end
        checks++;
        if (hs_cnt != 96) begin
            errors++;
            $display("FAIL line_hsync_width got=%0d exp=96", hs_cnt);
        end
        checks++;
        if (hs_first != 656) begin
            errors++;
            $display("FAIL line_hsync_start got=%0d exp=656", hs_first);
        end
        checks++;
        if (ls_cnt != 1 || ls !== 1'b1) begin
            errors++;
            $display("FAIL line_start_period count=%0d at800=%b exp=1,1", ls_cnt, ls);
        end
    endtask

    task automatic test_small_frames();
        int fs_cnt, vs_cnt, vs_first, de_cnt, hs_cnt;
        logic [25:0] got, exp;
        fs_cnt = 0; vs_cnt = 0; vs_first = -1; de_cnt = 0; hs_cnt = 0;
        do_reset();
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            got = {s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs};
            exp = model_small(k);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL small_sample k=%0d got=%h exp=%h", k, got, exp);
            end
            if (s_fs) fs_cnt++;
            if (k < 35) begin
                if (s_de) de_cnt++;
                if (!s_hsync) hs_cnt++;
                if (!s_vsync) begin
                    vs_cnt++;
                    if (vs_first < 0) begin
                        vs_first = k;
                        checks++;
                        if (s_ls !== 1'b1) begin
                            errors++;
                            $display("FAIL small_vsync_on_line_start got=%b exp=1", s_ls);
                        end
                    end
                end
            end
        end
        checks++;
        if (fs_cnt != 3) begin
            errors++;
            $display("FAIL small_frame_period fs_count=%0d exp=3", fs_cnt);
        end
        checks++;
        if (vs_cnt != 7 || vs_first != 21) begin
            errors++;
            $display("FAIL small_vsync width=%0d start=%0d exp=7,21", vs_cnt, vs_first);
        end
        checks++;
        if (de_cnt != 8) begin
            errors++;
            $display("FAIL small_de_count got=%0d exp=8", de_cnt);
        end
        checks++;
        if (hs_cnt != 5) begin
            errors++;
            $display("FAIL small_hsync_count got=%0d exp=5", hs_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [25:0] got, exp, rst_val;
        rst_val = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};
        do_reset();
        repeat (1901) @(negedge clk);
        got = {hsync, vsync, de, hpos, vpos, ls, fs};
        exp = model_def(1900);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mid_before_reset got=%h exp=%h", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({hsync, vsync, de, hpos, vpos, ls, fs} !== rst_val) begin
            errors++;
            $display("FAIL mid_async_reset got=%h exp=%h", {hsync, vsync, de, hpos, vpos, ls, fs}, rst_val);
        end
        checks++;
        if ({s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs} !== rst_val) begin
            errors++;
            $display("FAIL mid_async_reset_small got=%h exp=%h",
                     {s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs}, rst_val);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = {hsync, vsync, de, hpos, vpos, ls, fs};
            exp = model_def(k);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_restart k=%0d got=%h exp=%h", k, got, exp);
            end
            got = {s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs};
            exp = model_small(k);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_restart_small k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

`ifdef VGATG_CLKEN_EN
    task automatic test_clken();
        int fs_cnt, de_cnt;
        logic ce_edge;
        logic [25:0] got, prev;
        fs_cnt = 0; de_cnt = 0; ce_edge = 1'b1; prev = '0;
        ce = 1'b1;
        do_reset();
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            got = {s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs};
            if (k > 0 && !ce_edge) begin
                checks++;
                if (got !== prev) begin
                    errors++;
                    $display("FAIL clken_hold k=%0d got=%h exp=%h", k, got, prev);
                end
            end
            if (k < 2) begin
                checks++;
                if (s_fs !== 1'b1) begin
                    errors++;
                    $display("FAIL clken_fs_stretch k=%0d got=%b exp=1", k, s_fs);
                end
            end
            if (s_fs) fs_cnt++;
            if (s_de) de_cnt++;
            prev    = got;
            ce      = ~ce;
            ce_edge = ce;
        end
        checks++;
        if (fs_cnt != 4 || de_cnt != 32) begin
            errors++;
            $display("FAIL clken_periods fs=%0d de=%0d exp=4,32", fs_cnt, de_cnt);
        end
        ce = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b1;
`ifdef VGATG_CLKEN_EN
        ce = 1'b1;
`endif
        #1;
        test_reset();
        test_line();
        test_small_frames();
        test_mid_reset();
`ifdef VGATG_CLKEN_EN
        test_clken();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
